// File: rtl/grid_readout_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_readout_if                                              |
// | Description : Snapshot input and row-stream handshake of grid_readout.     |
// |               ROW_PARITY exists only with GRID_READOUT_PARITY_EN.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface grid_readout_if #(
    parameter int DATA_SIZE = 64,
    parameter int ROW_WIDTH = 8
);
    localparam int c_rows  = DATA_SIZE / ROW_WIDTH;
    localparam int c_idx_w = $clog2(c_rows);

    logic [DATA_SIZE-1:0] mem_in;
    logic                 start;
    logic                 row_ready;
    logic                 row_valid;
    logic [ROW_WIDTH-1:0] row_data;
    logic [c_idx_w-1:0]   row_index;
    logic                 busy;
    logic                 frame_done;
`ifdef GRID_READOUT_PARITY_EN
    logic                 row_parity;

    modport master (
        input  mem_in, start, row_ready,
        output row_valid, row_data, row_index, busy, frame_done, row_parity
    );
    modport slave (
        output mem_in, start, row_ready,
        input  row_valid, row_data, row_index, busy, frame_done, row_parity
    );
`else
    modport master (
        input  mem_in, start, row_ready,
        output row_valid, row_data, row_index, busy, frame_done
    );
    modport slave (
        output mem_in, start, row_ready,
        input  row_valid, row_data, row_index, busy, frame_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/grid_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grid_readout                                                 |
// | Description : Snapshots the generation word on start and streams it out   |
// |               row by row, lowest row first. Option: GRID_READOUT_PARITY_EN |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module grid_readout #(
    parameter int DATA_SIZE = 64,
    parameter int ROW_WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    grid_readout_if.master bus
);
    localparam int c_rows  = DATA_SIZE / ROW_WIDTH;
    localparam int c_idx_w = $clog2(c_rows);
    localparam logic [c_idx_w-1:0] c_last_row = c_idx_w'(c_rows - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                       r_state;
    logic [c_rows-1:0][ROW_WIDTH-1:0] r_snapshot;
    logic [c_idx_w-1:0]               r_count;
    logic                             w_xfer;
    logic                             w_last;

    assign w_xfer = (r_state == c_st_send) && bus.row_ready;
    assign w_last = (r_count == c_last_row);

    // The snapshot decouples the frame from later memory writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_snapshot <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_snapshot <= bus.mem_in;
                        r_count    <= '0;
                        r_state    <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= c_st_done;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.row_valid  = (r_state == c_st_send);
    assign bus.busy       = (r_state == c_st_send) || (r_state == c_st_done);
    assign bus.frame_done = (r_state == c_st_done);
    assign bus.row_data   = r_snapshot[r_count];
    assign bus.row_index  = r_count;

`ifdef GRID_READOUT_PARITY_EN
    logic r_parity;

    // Parity tracks the row that will be presented next, and is cleared outside SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_parity <= ^bus.mem_in[ROW_WIDTH-1:0];
                    end
                end
                c_st_send: begin
                    if (w_xfer) begin
                        r_parity <= w_last ? 1'b0 : ^r_snapshot[r_count + 1'b1];
                    end
                end
                default: r_parity <= 1'b0;
            endcase
        end
    end

    assign bus.row_parity = r_parity;
`endif
endmodule
`default_nettype wire

// File: tb/tb_grid_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_grid_readout                                              |
// | Description : Self-checking bench for grid_readout (16-bit grid, 4 cols).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_grid_readout;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grid_readout_if #(.DATA_SIZE(16), .ROW_WIDTH(4)) bus ();
    grid_readout #(.DATA_SIZE(16), .ROW_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
        logic       par;
    } row_t;

    // exp_rows lists row 0 in the top nibble; exp_par lists row 0 in bit 3.
    typedef struct {
        logic [15:0] mem;
        logic [15:0] exp_rows;
        logic [3:0]  exp_par;
        logic [7:0]  ready_pat;
    } vec_t;

    row_t sb_q[$];
    vec_t vt[5];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] exp_rows, input logic [3:0] exp_par);
        row_t r;
        for (int i = 0; i < 4; i++) begin
            r.idx  = 2'(i);
            r.data = exp_rows[15-4*i -: 4];
            r.par  = exp_par[3-i];
            sb_q.push_back(r);
        end
    endtask

    task automatic wait_done(input string name, input int bound);
        int c = 0;
        while (bus.frame_done !== 1'b1 && c < bound) begin
            tick();
            c++;
        end
        check(name, bus.frame_done, 1);
    endtask

    // Scoreboard monitor: every accepted row is compared against the queue head.
    always @(negedge clk) begin
        row_t e;
        if (!reset && bus.row_valid && bus.row_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_row", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_row_index", bus.row_index, e.idx);
                check("sb_row_data", bus.row_data, e.data);
`ifdef GRID_READOUT_PARITY_EN
                check("sb_row_parity", bus.row_parity, e.par);
`endif
            end
        end
`ifdef GRID_READOUT_PARITY_EN
        if (!reset && !bus.row_valid) check("parity_idle_zero", bus.row_parity, 0);
`endif
    end

    initial begin
        logic [15:0] t2_rows;
        int          dcount;

        vt[0] = '{mem: 16'hA5C3, exp_rows: 16'h3C5A, exp_par: 4'b0000, ready_pat: 8'hFF};
        vt[1] = '{mem: 16'h1234, exp_rows: 16'h4321, exp_par: 4'b1011, ready_pat: 8'b0101_0011};
        vt[2] = '{mem: 16'h7301, exp_rows: 16'h1037, exp_par: 4'b1001, ready_pat: 8'b1100_1001};
        vt[3] = '{mem: 16'h8E6F, exp_rows: 16'hF6E8, exp_par: 4'b0011, ready_pat: 8'b1000_0001};
        vt[4] = '{mem: 16'h0F0F, exp_rows: 16'hF0F0, exp_par: 4'b0000, ready_pat: 8'b0010_0100};

        // Reset held with START high: nothing may start.
        bus.mem_in = 16'hFFFF;
        bus.start = 1'b1;
        bus.row_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", bus.row_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.frame_done, 0);
            check("rst_index", bus.row_index, 0);
            check("rst_data", bus.row_data, 0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        bus.row_ready = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);

        // Streaming with exact latency.
        t2_rows = 16'h3C5A;
        bus.mem_in = 16'hA5C3;
        bus.row_ready = 1'b1;
        bus.start = 1'b1;
        push_frame(16'h3C5A, 4'b0000);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", bus.row_valid, 1);
            check("t2_index", bus.row_index, i);
            check("t2_data", bus.row_data, t2_rows[15-4*i -: 4]);
            tick();
        end
        check("t2_frame_done", bus.frame_done, 1);
        check("t2_done_valid", bus.row_valid, 0);
        check("t2_done_busy", bus.busy, 1);
        tick();
        check("t2_busy_low", bus.busy, 0);
        check("t2_done_low", bus.frame_done, 0);

        // Backpressure on row 1.
        bus.mem_in = 16'h1234;
        bus.row_ready = 1'b0;
        bus.start = 1'b1;
        push_frame(16'h4321, 4'b1011);
        tick();
        bus.start = 1'b0;
        bus.mem_in = 16'h0000;
        check("t3_row0_data", bus.row_data, 4'h4);
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_valid", bus.row_valid, 1);
            check("t3_hold_index", bus.row_index, 1);
            check("t3_hold_data", bus.row_data, 4'h3);
        end
        bus.row_ready = 1'b1;
        wait_done("t3_done", 20);
        tick();

        // Snapshot isolation and START ignored while busy.
        bus.mem_in = 16'hFFFF;
        bus.start = 1'b1;
        push_frame(16'hFFFF, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        tick();
        bus.mem_in = 16'h0000;
        dcount = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.frame_done === 1'b1) dcount++;
            tick();
        end
        check("t4_one_done", dcount, 1);
        check("t4_idle_busy", bus.busy, 0);
        check("t4_idle_valid", bus.row_valid, 0);
        tick();
        bus.start = 1'b0;
        check("t4_f2_valid", bus.row_valid, 1);
        check("t4_f2_index", bus.row_index, 0);
        check("t4_f2_data", bus.row_data, 0);
        wait_done("t4_f2_done", 20);
        tick();

        // Abort by reset during row 2.
        bus.mem_in = 16'h9876;
        bus.start = 1'b1;
        push_frame(16'h6789, 4'b0110);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("t5_row2_index", bus.row_index, 2);
        reset = 1'b1;
        tick();
        check("t5_abort_valid", bus.row_valid, 0);
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_done", bus.frame_done, 0);
        check("t5_sb_left", sb_q.size(), 2);
        sb_q.delete();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", bus.frame_done, 0);
            check("t5_no_valid", bus.row_valid, 0);
        end
        bus.mem_in = 16'h4321;
        bus.start = 1'b1;
        push_frame(16'h1234, 4'b1101);
        tick();
        bus.start = 1'b0;
        check("t5_restart_index", bus.row_index, 0);
        check("t5_restart_data", bus.row_data, 4'h1);
        wait_done("t5_restart_done", 20);
        tick();

        // Table-driven frames with varied ready patterns.
        foreach (vt[v]) begin
            bus.mem_in = vt[v].mem;
            bus.row_ready = 1'b0;
            bus.start = 1'b1;
            push_frame(vt[v].exp_rows, vt[v].exp_par);
            tick();
            bus.start = 1'b0;
            bus.mem_in = ~vt[v].mem;
            for (int c = 0; c < 60; c++) begin
                bus.row_ready = vt[v].ready_pat[c % 8];
                tick();
                if (bus.frame_done === 1'b1) break;
            end
            check("vec_done", bus.frame_done, 1);
            check("vec_sb_empty", sb_q.size(), 0);
            tick();
            check("vec_idle", bus.busy, 0);
        end

        check("final_sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
